cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 117 +++++++++++
 tb/tb_cdb_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-requester result FIFOs (ALU, LSB) feeding one registered
// broadcast slot with round-robin grant. Define CDB_BYPASS_EN for same-edge bypass of empty FIFOs.
module cdb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        alu_config,
    input  logic [31:0] alu_val,
    input  logic [3:0]  alu_rob_entry,
    output logic        alu_full,
    input  logic        lsb_config,
    input  logic [31:0] lsb_val,
    input  logic [3:0]  lsb_rob_entry,
    output logic        lsb_full,
    output logic        cdb_config,
    output logic [31:0] cdb_val,
    output logic [3:0]  cdb_rob_entry
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef CDB_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif
    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_LSB = 1'b1;

    logic [35:0]   alu_mem [DEPTH];
    logic [AW-1:0] alu_rd;
    logic [AW-1:0] alu_wr;
    logic [CW-1:0] alu_cnt;

    logic [35:0]   lsb_mem [DEPTH];
    logic [AW-1:0] lsb_rd;
    logic [AW-1:0] lsb_wr;
    logic [CW-1:0] lsb_cnt;

    logic          last_grant;
    logic          flush;
    logic          alu_empty;
    logic          lsb_empty;
    logic          alu_req;
    logic          lsb_req;
    logic          alu_win;
    logic          lsb_win;
    logic          alu_byp;
    logic          lsb_byp;
    logic          alu_pop;
    logic          lsb_pop;
    logic          alu_push;
    logic          lsb_push;
    logic [35:0]   win_data;

    assign flush     = rst | rollback;
    assign alu_empty = (alu_cnt == '0);
    assign lsb_empty = (lsb_cnt == '0);
    assign alu_full  = (alu_cnt == CW'(DEPTH));
    assign lsb_full  = (lsb_cnt == CW'(DEPTH));

    // With bypass, a live input on an empty FIFO competes as if it were queued.
    always_comb begin
        alu_req  = !alu_empty || (BYPASS && alu_config);
        lsb_req  = !lsb_empty || (BYPASS && lsb_config);
        alu_win  = alu_req && (!lsb_req || (last_grant == GRANT_LSB));
        lsb_win  = lsb_req && !alu_win;
        alu_byp  = alu_win && alu_empty;
        lsb_byp  = lsb_win && lsb_empty;
        alu_pop  = alu_win && !alu_empty;
        lsb_pop  = lsb_win && !lsb_empty;
        alu_push = alu_config && !alu_full && !alu_byp;
        lsb_push = lsb_config && !lsb_full && !lsb_byp;
        win_data = '0;
        if (alu_win) begin
            win_data = alu_byp ? {alu_rob_entry, alu_val} : alu_mem[alu_rd];
        end else if (lsb_win) begin
            win_data = lsb_byp ? {lsb_rob_entry, lsb_val} : lsb_mem[lsb_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && rdy) begin
            if (alu_push) alu_mem[alu_wr] <= {alu_rob_entry, alu_val};
            if (lsb_push) lsb_mem[lsb_wr] <= {lsb_rob_entry, lsb_val};
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            alu_rd        <= '0;
            alu_wr        <= '0;
            alu_cnt       <= '0;
            lsb_rd        <= '0;
            lsb_wr        <= '0;
            lsb_cnt       <= '0;
            last_grant    <= GRANT_LSB;
            cdb_config    <= 1'b0;
            cdb_val       <= '0;
            cdb_rob_entry <= '0;
        end else if (rdy) begin
            if (alu_push) alu_wr <= alu_wr + AW'(1);
            if (alu_pop)  alu_rd <= alu_rd + AW'(1);
            if (lsb_push) lsb_wr <= lsb_wr + AW'(1);
            if (lsb_pop)  lsb_rd <= lsb_rd + AW'(1);
            alu_cnt    <= alu_cnt + CW'(alu_push) - CW'(alu_pop);
            lsb_cnt    <= lsb_cnt + CW'(lsb_push) - CW'(lsb_pop);
            cdb_config <= alu_win | lsb_win;
            if (alu_win || lsb_win) begin
                {cdb_rob_entry, cdb_val} <= win_data;
                last_grant               <= alu_win ? GRANT_ALU : GRANT_LSB;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (default build, DEPTH=4): latency, round-robin order,
// overflow drops, rollback flush, rdy freeze and sustained single-requester throughput.
module tb_cdb_arbiter;
    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        alu_config, lsb_config;
    logic [31:0] alu_val, lsb_val;
    logic [3:0]  alu_rob_entry, lsb_rob_entry;
    logic        alu_full, lsb_full;
    logic        cdb_config;
    logic [31:0] cdb_val;
    logic [3:0]  cdb_rob_entry;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    cdb_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .alu_config(alu_config), .alu_val(alu_val), .alu_rob_entry(alu_rob_entry), .alu_full(alu_full),
        .lsb_config(lsb_config), .lsb_val(lsb_val), .lsb_rob_entry(lsb_rob_entry), .lsb_full(lsb_full),
        .cdb_config(cdb_config), .cdb_val(cdb_val), .cdb_rob_entry(cdb_rob_entry)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cdb(input string tag, input logic cfg, input logic [3:0] rob, input logic [31:0] val);
        chk({tag, ".cfg"}, 64'(cdb_config), 64'(cfg));
        chk({tag, ".tag"}, 64'(cdb_rob_entry), 64'(rob));
        chk({tag, ".val"}, 64'(cdb_val), 64'(val));
    endtask

    task automatic idle_inputs();
        alu_config = 0; alu_val = '0; alu_rob_entry = '0;
        lsb_config = 0; lsb_val = '0; lsb_rob_entry = '0;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs(); tick(); rst = 0;
    endtask

    // Hand-traced broadcast tags for the overflow run; -1 means no broadcast on that edge.
    int ovf_tags [1:16] = '{-1, 0, 8, 1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 15, -1};

    initial begin
        rdy = 1; rollback = 0; rst = 1;
        idle_inputs();
        tick(); tick();
        chk_cdb("reset", 1'b0, 4'd0, 32'd0);
        chk("reset.alu_full", 64'(alu_full), 64'd0);
        chk("reset.lsb_full", 64'(lsb_full), 64'd0);
        rst = 0;

        // single ALU result: accepted at edge N, broadcast after edge N+1, for one cycle only
        alu_config = 1; alu_val = 32'h11; alu_rob_entry = 4'd3;
        tick();
        idle_inputs();
        chk("lat.edgeN.cfg", 64'(cdb_config), 64'd0);
        tick();
        chk_cdb("lat.edgeN1", 1'b1, 4'd3, 32'h11);
        tick();
        chk_cdb("lat.after", 1'b0, 4'd3, 32'h11);

        // both FIFOs with two entries: ALU first, then strict alternation
        do_reset();
        alu_config = 1; alu_val = 32'hA1; alu_rob_entry = 4'd1;
        lsb_config = 1; lsb_val = 32'hB8; lsb_rob_entry = 4'd8;
        tick();
        chk("rr.load.cfg", 64'(cdb_config), 64'd0);
        alu_val = 32'hA2; alu_rob_entry = 4'd2;
        lsb_val = 32'hB9; lsb_rob_entry = 4'd9;
        tick();
        idle_inputs();
        chk_cdb("rr.0", 1'b1, 4'd1, 32'hA1);
        tick(); chk_cdb("rr.1", 1'b1, 4'd8, 32'hB8);
        tick(); chk_cdb("rr.2", 1'b1, 4'd2, 32'hA2);
        tick(); chk_cdb("rr.3", 1'b1, 4'd9, 32'hB9);
        tick(); chk("rr.done.cfg", 64'(cdb_config), 64'd0);

        // both requesters push every cycle for 8 edges; FIFOs fill at half rate and
        // overflowing pushes (ALU tag 7, LSB tag 14) are dropped
        do_reset();
        for (int e = 1; e <= 16; e++) begin
            if (e <= 8) begin
                alu_config = 1; alu_rob_entry = 4'(e - 1); alu_val = 32'h100 + 32'(e - 1);
                lsb_config = 1; lsb_rob_entry = 4'(e + 7); lsb_val = 32'h200 + 32'(e + 7);
            end else begin
                idle_inputs();
            end
            tick();
            if (ovf_tags[e] < 0) begin
                chk($sformatf("ovf.e%0d.cfg", e), 64'(cdb_config), 64'd0);
            end else begin
                chk_cdb($sformatf("ovf.e%0d", e), 1'b1, 4'(ovf_tags[e]),
                        (ovf_tags[e] < 8 ? 32'h100 : 32'h200) + 32'(ovf_tags[e]));
            end
            if (e == 6) chk("ovf.e6.lsb_full", 64'(lsb_full), 64'd1);
            if (e == 7) begin
                chk("ovf.e7.alu_full", 64'(alu_full), 64'd1);
                chk("ovf.e7.lsb_full", 64'(lsb_full), 64'd0);
            end
            if (e == 8) begin
                chk("ovf.e8.alu_full", 64'(alu_full), 64'd0);
                chk("ovf.e8.lsb_full", 64'(lsb_full), 64'd1);
            end
        end
        chk("ovf.hold.tag", 64'(cdb_rob_entry), 64'd15);

        // rollback with buffered entries and live inputs: nothing survives
        alu_config = 1; alu_val = 32'h301; alu_rob_entry = 4'd1;
        lsb_config = 1; lsb_val = 32'h309; lsb_rob_entry = 4'd9;
        tick();
        alu_val = 32'h302; alu_rob_entry = 4'd2;
        lsb_val = 32'h30A; lsb_rob_entry = 4'd10;
        tick();
        rollback = 1; alu_val = 32'h303; alu_rob_entry = 4'd3;
        tick();
        rollback = 0; idle_inputs();
        chk_cdb("rb.edge", 1'b0, 4'd0, 32'd0);
        chk("rb.alu_full", 64'(alu_full), 64'd0);
        chk("rb.lsb_full", 64'(lsb_full), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rb.quiet%0d.cfg", i), 64'(cdb_config), 64'd0);
        end

        // rdy low freezes outputs and ignores inputs; order resumes afterwards
        alu_config = 1; alu_val = 32'h55; alu_rob_entry = 4'd5;
        lsb_config = 1; lsb_val = 32'h66; lsb_rob_entry = 4'd6;
        tick();
        lsb_config = 0; alu_val = 32'h77; alu_rob_entry = 4'd7;
        tick();
        chk_cdb("rdy.pre", 1'b1, 4'd5, 32'h55);
        rdy = 0;
        alu_config = 1; alu_val = 32'hCC; alu_rob_entry = 4'd12;
        lsb_config = 1; lsb_val = 32'hDD; lsb_rob_entry = 4'd13;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cdb($sformatf("rdy.hold%0d", i), 1'b1, 4'd5, 32'h55);
        end
        rdy = 1; idle_inputs();
        tick(); chk_cdb("rdy.res0", 1'b1, 4'd6, 32'h66);
        tick(); chk_cdb("rdy.res1", 1'b1, 4'd7, 32'h77);
        tick(); chk("rdy.res.done.cfg", 64'(cdb_config), 64'd0);

        // LSB alone, one push and one pop per cycle across pointer and tag wrap
        do_reset();
        for (int e = 1; e <= 22; e++) begin
            if (e <= 20) begin
                lsb_config = 1; lsb_rob_entry = 4'((e - 1) % 16); lsb_val = 32'h400 + 32'(e - 1);
            end else begin
                idle_inputs();
            end
            tick();
            if (e == 1 || e == 22) begin
                chk($sformatf("thr.e%0d.cfg", e), 64'(cdb_config), 64'd0);
            end else begin
                chk_cdb($sformatf("thr.e%0d", e), 1'b1, 4'((e - 2) % 16), 32'h400 + 32'(e - 2));
                chk($sformatf("thr.e%0d.lsb_full", e), 64'(lsb_full), 64'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end
endmodule
